// File: rtl/alu_op_feeder.sv
// alu_op_feeder: FIFO-buffered issue stage that drives the ALU input pins and paces multiplies.
// Latency: an entry pushed at edge N into an empty FIFO is on the ALU pins after edge N+1 (no bypass).
// Backpressure: in_ready = (fifo_cnt < DEPTH); the ALU side never stalls, only the post-multiply gap blocks pops.
// Optional feature: define ALU_FEED_CNT_EN to add the 16-bit issue_cnt output.
module alu_op_feeder #(
  parameter int WIDTH   = 8,
  parameter int CMD_W   = 4,
  parameter int DEPTH   = 4,
  parameter int MUL_GAP = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_opa,
  input  logic [WIDTH-1:0]        in_opb,
  input  logic                    in_cin,
  input  logic                    in_mode,
  input  logic [CMD_W-1:0]        in_cmd,
  input  logic [1:0]              in_inp_valid,
  output logic [WIDTH-1:0]        OPA,
  output logic [WIDTH-1:0]        OPB,
  output logic                    CIN,
  output logic                    MODE,
  output logic [CMD_W-1:0]        CMD,
  output logic [1:0]              INP_VALID,
  output logic                    CE,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  fifo_cnt
`ifdef ALU_FEED_CNT_EN
  ,
  output logic [15:0]             issue_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int GAP_W = $clog2(MUL_GAP + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  typedef struct packed {
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin;
    logic             mode;
    logic [CMD_W-1:0] cmd;
    logic [1:0]       iv;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           in_ent;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       state;
  logic [GAP_W-1:0] gap;
  logic             push;
  logic             pop;
  logic             head_issue;
  logic             head_mul;
  logic [CNT_W-1:0] cnt_next;

  // Handshake, head decode and occupancy arithmetic; pops are blocked only while a multiply gap runs.
  always_comb begin
    in_ent.opa  = in_opa;
    in_ent.opb  = in_opb;
    in_ent.cin  = in_cin;
    in_ent.mode = in_mode;
    in_ent.cmd  = in_cmd;
    in_ent.iv   = in_inp_valid;
    in_ready    = (fifo_cnt < CNT_W'(DEPTH));
    push        = in_valid && in_ready;
    pop         = (state != S_GAP) && (fifo_cnt != '0);
    head        = mem[rd_ptr];
    head_issue  = (head.iv != 2'b00);
    head_mul    = head_issue && head.mode &&
                  ((head.cmd == CMD_W'(9)) || (head.cmd == CMD_W'(10)));
    cnt_next    = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    busy        = (fifo_cnt != '0) || (gap != '0);
  end

  // Entry storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_ent;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= cnt_next;
    end
  end

  // Issue FSM: register the popped head onto the ALU pins, or count down the post-multiply gap.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      gap       <= '0;
      OPA       <= '0;
      OPB       <= '0;
      CIN       <= 1'b0;
      MODE      <= 1'b0;
      CMD       <= '0;
      INP_VALID <= 2'b00;
      CE        <= 1'b0;
    end else begin
      INP_VALID <= 2'b00;
      CE        <= 1'b0;
      if (state == S_GAP) begin
        CE  <= 1'b1;
        gap <= gap - GAP_W'(1);
        if (gap == GAP_W'(1)) state <= (fifo_cnt != '0) ? S_ISSUE : S_IDLE;
      end else if (pop) begin
        CE <= 1'b1;
        // A zero operand-valid code is consumed without touching the held pins.
        if (head_issue) begin
          OPA       <= head.opa;
          OPB       <= head.opb;
          CIN       <= head.cin;
          MODE      <= head.mode;
          CMD       <= head.cmd;
          INP_VALID <= head.iv;
        end
        if (head_mul && (MUL_GAP > 0)) begin
          gap   <= GAP_W'(MUL_GAP);
          state <= S_GAP;
        end else begin
          state <= (cnt_next != '0) ? S_ISSUE : S_IDLE;
        end
      end else begin
        state <= S_IDLE;
      end
    end
  end

`ifdef ALU_FEED_CNT_EN
  // Count entries actually presented to the ALU; wraps at 16 bits.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) issue_cnt <= '0;
    else if (pop && head_issue) issue_cnt <= issue_cnt + 16'd1;
  end
`endif

endmodule
